event_fire_scheduler: RTL and testbench
=======================================

// Module: event_fire_scheduler
// PURPOSE
//  Synchronous scheduler for a bank of N_SRC negedge-triggered event sources.
//  Arbitrates level requests round-robin and drives each source's switch input
//  low for a programmable time, then high for a programmable recovery gap.
//  One source is fired at a time. Each completed fire is acknowledged with a
//  1-cycle pulse. Sits between control logic and the event-source bank.
// PARAMETERS
//  N_SRC   4   number of event sources / requesters (>=2)
//  CNT_W   8   width of low/gap cycle counts
//  FCNT_W  16  width of the fire counter
// PORTS
//  clk          in   1          clock
//  rstn         in   1          synchronous active-low reset
//  enable_i     in   1          1 = new grants allowed
//  req_i        in   N_SRC      level request per source; held until ack
//  low_cycles_i in   CNT_W      switch-low duration L (0 treated as 1)
//  gap_cycles_i in   CNT_W      extra recovery cycles G after DONE (0 allowed)
//  switch_o     out  N_SRC      to event-source switch; idle 1, falling edge = fire
//  ack_o        out  N_SRC      1-cycle pulse: fire of that source completed
//  busy_o       out  1          1 in any state other than IDLE
//  cur_src_o    out  clog2(N)   granted source index; valid while busy_o
//  fire_cnt_o   out  FCNT_W     total completed fires, wraps to 0
// BEHAVIOUR
//  Reset (rstn=0 at edge): switch_o all 1, ack_o 0, busy_o 0, cur_src_o 0,
//   fire_cnt_o 0, rr pointer 0, state IDLE. Mid-sequence reset aborts with no ack.
//  All outputs are registered.
//  FSM: IDLE -> LOW -> DONE -> GAP -> IDLE. GAP is skipped when G=0.
//  IDLE at cycle T:
//   - if enable_i & |req_i: pick the first set req at or after rr pointer,
//     wrapping. Latch g, L, G. Go to LOW.
//   - switch_o[g]=0 from T+1. cur_src_o=g and busy_o=1 from T+1.
//  LOW: lasts exactly L cycles (T+1..T+L). Only bit g of switch_o is 0.
//  DONE: 1 cycle (T+L+1).
//   - switch_o[g]=1, ack_o[g]=1, fire_cnt_o+1.
//   - rr pointer <= (g+1) mod N_SRC.
//  GAP: G cycles (T+L+2..T+L+1+G). All switch_o are 1.
//  IDLE again at T+L+G+2. Fire period = L+G+2 cycles back-to-back.
//  Requester handshake:
//   - drop req_i on the cycle after seeing ack_o.
//   - req_i still high in IDLE = new request.
//   - dropping req_i while granted does not abort the sequence.
//  enable_i=0 blocks only new grants; an in-flight sequence completes.
//  low_cycles_i / gap_cycles_i are sampled only at grant; later changes apply
//   to the next grant.
//  At most one ack_o bit high per cycle. switch_o never has two bits low.
//  Simultaneous requests: round-robin from the pointer, so there is no
//   starvation (each requester waits <= N_SRC-1 fires).
//  fire_cnt_o wraps from 2^FCNT_W-1 to 0 silently.
// TESTING
//  1. L=3,G=0, req_i=0001 at T: switch_o[0]=0 T+1..T+3; ack_o[0] at T+4;
//     busy_o low at T+5.
//  2. L=0,G=2: switch_o low exactly 1 cycle; next grant decided 5 cycles
//     after previous grant.
//  3. req_i=1111 held (each dropped after its ack), L=2,G=1: fire order 0,1,2,3;
//     fire_cnt_o=4; ack spacing 5 cycles.
//  4. Pointer=2, req_i=0011 -> source 0 granted first, then 1.
//  5. enable_i=0 during LOW of src1 -> src1 completes with ack; no new grant
//     until enable_i=1.
//  6. rstn=0 in mid-LOW -> next edge switch_o=1111, busy_o=0, no ack, pointer 0.
//     Also: force fire_cnt_o=FFFF, one fire -> 0000.

Source files
------------

// File: rtl/event_fire_scheduler.sv
// event_fire_scheduler
//   Round-robin scheduler for a bank of negedge-triggered event sources. Each
//   grant drives the chosen source's switch low for L cycles. A one-cycle DONE
//   state follows, then G recovery cycles. Only one source is fired at a time.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   enable_i       allow new grants (an in-flight sequence always completes)
//   req_i          level request per source, held by requester until ack
//   low_cycles_i   switch-low duration L (0 behaves as 1), sampled at grant
//   gap_cycles_i   recovery cycles G after DONE (0 allowed), sampled at grant
//   switch_o       per-source switch, idle high, falling edge fires
//   ack_o          one-cycle pulse when the granted source's fire completes
//   busy_o         high whenever the FSM is not idle
//   cur_src_o      granted source index, valid while busy_o
//   fire_cnt_o     completed-fire counter, wraps silently
module event_fire_scheduler #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned FCNT_W = 16,
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable_i,
  input  logic [N_SRC-1:0]  req_i,
  input  logic [CNT_W-1:0]  low_cycles_i,
  input  logic [CNT_W-1:0]  gap_cycles_i,
  output logic [N_SRC-1:0]  switch_o,
  output logic [N_SRC-1:0]  ack_o,
  output logic              busy_o,
  output logic [SRC_W-1:0]  cur_src_o,
  output logic [FCNT_W-1:0] fire_cnt_o
);

  typedef enum logic [1:0] {StIdle, StLow, StDone, StGap} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [N_SRC-1:0]   switch_q, switch_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [FCNT_W-1:0]  fire_cnt_q, fire_cnt_d;

  // Round-robin pick: first set request at or after the pointer, wrapping.
  logic             found;
  logic [SRC_W-1:0] pick;

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = (32'(ptr_q) + i) % N_SRC;
      if (!found && req_i[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    src_d      = src_q;
    ptr_d      = ptr_q;
    switch_d   = switch_q;
    ack_d      = '0;
    busy_d     = busy_q;
    fire_cnt_d = fire_cnt_q;

    case (state_q)
      StIdle: begin
        if (enable_i && found) begin
          state_d        = StLow;
          src_d          = pick;
          cnt_d          = (low_cycles_i == '0) ? CNT_W'(1) : low_cycles_i;
          gap_d          = gap_cycles_i;
          switch_d       = '1;
          switch_d[pick] = 1'b0;
          busy_d         = 1'b1;
        end
      end
      StLow: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d       = StDone;
          switch_d      = '1;
          ack_d[src_q]  = 1'b1;
          fire_cnt_d    = fire_cnt_q + FCNT_W'(1);
          ptr_d         = (src_q == SRC_W'(N_SRC - 1)) ? '0 : src_q + SRC_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        if (gap_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          state_d = StGap;
          cnt_d   = gap_q;
        end
      end
      StGap: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        switch_d = '1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gap_q      <= '0;
      src_q      <= '0;
      ptr_q      <= '0;
      switch_q   <= '1;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      src_q      <= src_d;
      ptr_q      <= ptr_d;
      switch_q   <= switch_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign switch_o   = switch_q;
  assign ack_o      = ack_q;
  assign busy_o     = busy_q;
  assign cur_src_o  = src_q;
  assign fire_cnt_o = fire_cnt_q;

endmodule

// File: tb/tb_event_fire_scheduler.sv
// Bench for event_fire_scheduler: a table of single-fire vectors plus
// hand-written sequences for round-robin bursts, enable gating and reset.
// A second instance with a 3-bit fire counter exercises counter wrap.
module tb_event_fire_scheduler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] low = '0;
  logic [7:0] gap = '0;

  logic [3:0]  switch_o, ack_o;
  logic        busy_o;
  logic [1:0]  cur_src_o;
  logic [15:0] fire_cnt_o;

  logic [3:0]  switch_s, ack_s;
  logic        busy_s;
  logic [1:0]  cur_src_s;
  logic [2:0]  fire_cnt_s;

  always #5 clk = ~clk;

  event_fire_scheduler #(.N_SRC(4), .CNT_W(8), .FCNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .enable_i(enable), .req_i(req),
    .low_cycles_i(low), .gap_cycles_i(gap), .switch_o(switch_o), .ack_o(ack_o),
    .busy_o(busy_o), .cur_src_o(cur_src_o), .fire_cnt_o(fire_cnt_o)
  );

  event_fire_scheduler #(.N_SRC(4), .CNT_W(8), .FCNT_W(3)) u_dut_small (
    .clk(clk), .rstn(rstn), .enable_i(enable), .req_i(req),
    .low_cycles_i(low), .gap_cycles_i(gap), .switch_o(switch_s), .ack_o(ack_s),
    .busy_o(busy_s), .cur_src_o(cur_src_s), .fire_cnt_o(fire_cnt_s)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected source of each ack, pushed at request time.
  int          exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          mon_s;

  always @(negedge clk) begin
    if (rstn) begin
      check("switch_one_low", 32'($countones(~switch_o) <= 1), 1);
      check("ack_onehot0", 32'($countones(ack_o) <= 1), 1);
      if (ack_o != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 0);
        end else begin
          mon_s = exp_q.pop_front();
          exp_cnt = exp_cnt + 16'd1;
          check("ack_src", 32'(ack_o), 32'(1 << mon_s));
          check("fire_cnt", 32'(fire_cnt_o), 32'(exp_cnt));
          check("fire_cnt_wrap", 32'(fire_cnt_s), 32'(exp_cnt[2:0]));
        end
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] l;
    logic [7:0] g;
    int         src;
    int         low_n;
    int         per;
  } vec_t;

  vec_t vecs[9];

  // Called just after a negedge with the DUT idle. One fire; req dropped on ack.
  task automatic run_fire(input vec_t v);
    int first_low = 0;
    int low_n = 0;
    int ack_k = 0;
    int idle_k = 0;
    req = v.req; enable = 1'b1; low = v.l; gap = v.g;
    exp_q.push_back(v.src);
    for (int k = 1; k <= 600 && idle_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("grant_src", 32'(cur_src_o), 32'(v.src));
        check("grant_switch", 32'(switch_o), 32'(~(4'b0001 << v.src) & 4'hF));
        check("grant_busy", 32'(busy_o), 1);
        low = 8'd7; gap = 8'd9;  // must not affect the sequence in flight
      end
      if (switch_o != 4'hF) begin
        low_n++;
        if (first_low == 0) first_low = k;
      end
      if (ack_o != '0) begin
        ack_k = k;
        req = '0;
      end
      if (!busy_o) idle_k = k;
    end
    check("first_low", 32'(first_low), 1);
    check("low_len", 32'(low_n), 32'(v.low_n));
    check("ack_time", 32'(ack_k), 32'(v.low_n + 1));
    check("period", 32'(idle_k), 32'(v.per));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req = '0; enable = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int   ack_k[$];
    int   busy_after;
    logic seen_idle;
    logic got;

    vecs[0] = '{4'b0001, 8'd3,   8'd0,   0, 3,   5};
    vecs[1] = '{4'b0001, 8'd0,   8'd2,   0, 1,   5};
    vecs[2] = '{4'b0010, 8'd1,   8'd0,   1, 1,   3};
    vecs[3] = '{4'b0011, 8'd2,   8'd1,   0, 2,   5};
    vecs[4] = '{4'b0011, 8'd2,   8'd1,   1, 2,   5};
    vecs[5] = '{4'b1001, 8'd4,   8'd3,   3, 4,   9};
    vecs[6] = '{4'b1100, 8'd1,   8'd1,   2, 1,   4};
    vecs[7] = '{4'b1100, 8'd255, 8'd255, 3, 255, 512};
    vecs[8] = '{4'b0110, 8'd1,   8'd0,   1, 1,   3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_switch", 32'(switch_o), 32'hF);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cur_src", 32'(cur_src_o), 0);
    check("rst_fire_cnt", 32'(fire_cnt_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_fire(vecs[i]);
    check("table_fire_cnt", 32'(fire_cnt_o), 9);
    check("table_fire_cnt_small", 32'(fire_cnt_s), 1);  // 9 mod 8

    // All four requesting, held until own ack: order 0,1,2,3, acks 5 apart.
    do_reset();
    req = 4'b1111; enable = 1'b1; low = 8'd2; gap = 8'd1;
    for (int s = 0; s < 4; s++) exp_q.push_back(s);
    for (int k = 1; k <= 100 && ack_k.size() < 4; k++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        ack_k.push_back(k);
        req = req & ~ack_o;
      end
    end
    check("burst_acks", 32'(ack_k.size()), 4);
    for (int i = 1; i < ack_k.size(); i++)
      check("burst_spacing", 32'(ack_k[i] - ack_k[i-1]), 5);
    for (int k = 0; k < 20 && busy_o; k++) @(negedge clk);
    check("burst_fire_cnt", 32'(fire_cnt_o), 4);
    check("burst_idle", 32'(busy_o), 0);

    // enable dropped during LOW of src1: src1 completes, src0 waits.
    req = 4'b0010; enable = 1'b1; low = 8'd3; gap = 8'd0;
    exp_q.push_back(1);
    @(negedge clk);
    check("en_grant", 32'(cur_src_o), 1);
    enable = 1'b0; req = 4'b0011;
    got = 1'b0; seen_idle = 1'b0; busy_after = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        got = 1'b1;
        req = req & ~ack_o;
      end
      if (seen_idle && busy_o) busy_after++;
      if (!busy_o) seen_idle = 1'b1;
    end
    check("en_ack_seen", 32'(got), 1);
    check("en_no_grant", 32'(busy_after), 0);
    enable = 1'b1;
    exp_q.push_back(0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        got = 1'b1;
        req = '0;
      end
    end
    check("en_resume_ack", 32'(got), 1);
    for (int k = 0; k < 20 && busy_o; k++) @(negedge clk);

    // Move pointer to 3, then reset mid-LOW: abort, no ack, pointer to 0.
    run_fire('{4'b0100, 8'd1, 8'd0, 2, 1, 3});
    req = 4'b0100; low = 8'd10; gap = 8'd0;
    exp_q.push_back(2);
    repeat (3) @(negedge clk);
    check("mid_low_switch", 32'(switch_o), 32'b1011);
    rstn = 1'b0; req = '0;
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    check("abort_switch", 32'(switch_o), 32'hF);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_ack", 32'(ack_o), 0);
    check("abort_cur_src", 32'(cur_src_o), 0);
    check("abort_fire_cnt", 32'(fire_cnt_o), 0);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_still_idle", 32'(busy_o), 0);
    run_fire('{4'b1001, 8'd1, 8'd0, 0, 1, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
